// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_share_arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding system's view.
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;

  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_id;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_zero;
  logic              rsp_ready;

  logic              busy;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_ctrl, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_ctrl, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin arbitration with fixed priority to requester 0.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  logic [1:0]        state;
  logic              last_grant;
  logic              grant_id;
  logic              pick;
  logic              fire0;
  logic              fire1;

  logic [CTRL_W-1:0] op_ctrl;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;

  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic              rsp_zero_q;

  // Handshakes: a transfer happens on a rising edge where valid && ready. reqX_ready only rises
  // in IDLE for the arbitration winner; rsp_valid holds with stable payload until rsp_ready.
  always_comb begin
    pick = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    pick = !bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) pick = ~last_grant;
    else                                  pick = !bus.req0_valid;
`endif
  end

  assign bus.req0_ready = (state == S_IDLE) && bus.req0_valid && !pick;
  assign bus.req1_ready = (state == S_IDLE) && bus.req1_valid && pick;
  assign fire0 = bus.req0_valid && bus.req0_ready;
  assign fire1 = bus.req1_valid && bus.req1_ready;

  // ALU inputs come straight from the operand registers, so they hold their last values.
  assign bus.alu_ctrl   = op_ctrl;
  assign bus.alu_a      = op_a;
  assign bus.alu_b      = op_b;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = (state != S_IDLE);
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      op_ctrl      <= '0;
      op_a         <= '0;
      op_b         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire0 || fire1) begin
            op_ctrl    <= fire1 ? bus.req1_ctrl : bus.req0_ctrl;
            op_a       <= fire1 ? bus.req1_a    : bus.req0_a;
            op_b       <= fire1 ? bus.req1_b    : bus.req0_b;
            grant_id   <= fire1;
            last_grant <= fire1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result_q <= bus.alu_result;
          rsp_zero_q   <= bus.alu_zero;
          rsp_id_q     <= grant_id;
          rsp_valid_q  <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (3-bit ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt) between two requesters.
- Requester 0 is the core execute path; requester 1 is an auxiliary unit, e.g. an address generator or debug unit.
- Requests use valid/ready handshakes, are arbitrated round-robin, and are sequenced through a 3-state FSM.
- The ALU result and flags are registered and returned to the granted requester.

Parameters:
- WIDTH, 32, operand/result width in bits
- CTRL_W, 3, ALUControl width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_ctrl  input  CTRL_W  requester 0 ALUControl
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b  same as requester 0, for requester 1
- alu_ctrl  output  CTRL_W  to shared ALU
- alu_a, alu_b  output  WIDTH  to shared ALU
- alu_result  input  WIDTH  from shared ALU, combinational
- alu_zero  input  1  from shared ALU
- rsp_valid  output  1  result available
- rsp_id  output  1  requester the result belongs to
- rsp_result  output  WIDTH  registered ALU result
- rsp_zero  output  1  registered zero flag
- rsp_ready  input  1  consumer accepts result
- busy  output  1  FSM not IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Reset → IDLE.
- Reset values: all outputs 0, including alu_ctrl=000, alu_a=alu_b=0, rsp_*=0, busy=0; last_grant=1, so requester 0 wins first.
- IDLE:
  - reqX_ready is asserted combinationally only for the arbitration winner, and only in IDLE.
  - Round-robin: if both are valid, grant the requester not equal to last_grant. If only one is valid, grant it.
  - On handshake (valid & ready): latch ctrl/a/b into operand registers, set grant_id, update last_grant, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_ctrl/alu_a/alu_b are driven from the operand registers (registered outputs, stable the whole cycle).
  - At the end of the cycle, capture alu_result → rsp_result and alu_zero → rsp_zero; set rsp_valid=1, rsp_id=grant_id; go to RESP.
- RESP:
  - rsp_valid held with stable rsp_result/rsp_zero/rsp_id until rsp_ready=1.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. No new request is accepted in the same cycle, so at most one operation is in flight.
- Latency: handshake in cycle N; ALU driven in N+1; rsp_valid high from N+2. Minimum issue interval is 3 cycles with rsp_ready held high.
- ALU operand outputs keep their last values outside EXEC; they are not re-zeroed.
- A requester dropping valid without a handshake is legal and no state changes.
- Requester 1 is never starved: after any grant to requester 0, a pending requester 1 wins the next arbitration.
- Reset asserted mid-operation, in EXEC or RESP: the in-flight result is discarded with no rsp_valid pulse, and the next state is IDLE with reset values.
- busy = (state != IDLE).

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority. Requester 0 always wins when both are valid. last_grant is still tracked but has no effect on arbitration.
- Undefined: round-robin exactly as specified above.

Test Plan:
- Single op, requester 0: req0 ctrl=000, a=5, b=7, rsp_ready=1 → req0_ready in cycle N; alu_ctrl=000/a=5/b=7 in N+1; rsp_valid in N+2 with rsp_result=12, rsp_zero=0, rsp_id=0; busy high N+1..N+2.
- Subtract-to-zero, requester 1: ctrl=001, a=9, b=9 → rsp_result=0, rsp_zero=1, rsp_id=1.
- Both valid continuously after reset, rsp_ready=1 → grants alternate 0,1,0,1; one result every 3 cycles. With ALU_ARB_FIXED_PRIO_EN defined → all grants go to 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid on a slt op (a=0xFFFFFFFF, b=1) → rsp_result=1 held stable; req ready stays 0 throughout; IDLE is reached the cycle after rsp_ready=1.
- Reset mid-EXEC: assert rst in the EXEC cycle → no rsp_valid ever asserts for that op; all outputs read 0 the next cycle; a following req0 is granted first.
- Withdrawn request: req1_valid pulses while a req0 operation is in RESP → no grant to 1 and rsp unaffected; later sustained req1_valid is granted normally.
